// File: rtl/home_event_arbiter_pkg.sv
// Shared encodings for the home event arbiter: FSM states, channel indices, display codes.
// No logic or latency of its own.
// Not applicable: this package carries no flow control.
package home_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    localparam int NUM_CH = 6;

    localparam logic [2:0] CH_FD   = 3'd0;
    localparam logic [2:0] CH_RD   = 3'd1;
    localparam logic [2:0] CH_FA   = 3'd2;
    localparam logic [2:0] CH_W    = 3'd3;
    localparam logic [2:0] CH_HEAT = 3'd4;
    localparam logic [2:0] CH_COOL = 3'd5;

    // Display codes follow the home-automation FSM state codes.
    localparam logic [2:0] DISP_IDLE = 3'd0;
    localparam logic [2:0] DISP_FD   = 3'd1;
    localparam logic [2:0] DISP_RD   = 3'd2;
    localparam logic [2:0] DISP_FA   = 3'd3;
    localparam logic [2:0] DISP_W    = 3'd4;
    localparam logic [2:0] DISP_HEAT = 3'd5;
    localparam logic [2:0] DISP_COOL = 3'd6;

    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [2:0] ch);
        return 6'b000001 << ch;
    endfunction

    function automatic logic [2:0] ch_disp(input logic [2:0] ch);
        return ch + 3'd1;
    endfunction

endpackage

// File: rtl/home_event_arbiter_if.sv
// Sensor/temperature inputs and actuator/display outputs of the home event arbiter.
// Pure wiring, zero latency.
// No backpressure: inputs are levels, outputs are registered levels.
interface home_event_arbiter_if;
    logic [3:0] sensors;
    logic [5:0] temp;
    logic [5:0] grant;
    logic [2:0] display;
    logic [5:0] pending;
    logic       busy;

    modport master (
        output sensors, temp,
        input  grant, display, pending, busy
    );

    modport slave (
        input  sensors, temp,
        output grant, display, pending, busy
    );
endinterface

// File: rtl/home_event_arbiter_rr_pick6.sv
// Six-channel picker: fire wins outright, the rest round-robin starting after rr_ptr.
// Purely combinational, zero latency.
// No backpressure; caller decides when the pick is consumed.
module rr_pick6
    import home_pkg::*;
(
    input  logic [NUM_CH-1:0] pending,
    input  logic [2:0]        rr_ptr,
    output logic [2:0]        sel,
    output logic              valid
);

    logic [3:0] idx;

    always_comb begin
        sel   = CH_FD;
        valid = 1'b0;
        idx   = 4'd0;
        if (pending[CH_FA]) begin
            sel   = CH_FA;
            valid = 1'b1;
        end else begin
            // Walk rr_ptr+1 .. rr_ptr+6 modulo 6; the first hit wins.
            for (int i = 1; i <= NUM_CH; i++) begin
                idx = {1'b0, rr_ptr} + 4'(i);
                if (idx >= 4'd6) begin
                    idx = idx - 4'd6;
                end
                if (!valid && (idx[2:0] != CH_FA) && pending[idx[2:0]]) begin
                    sel   = idx[2:0];
                    valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/home_event_arbiter.sv
// Latches sensor/temperature rising edges and grants one actuator at a time (dwell + guard).
// Rise-to-pending 1 cycle, pending-to-grant 1 more from IDLE; fire preempts in 1 cycle.
// No backpressure: events stay pending until served, repeated rises while pending merge.
module home_event_arbiter
    import home_pkg::*;
#(
    parameter int DWELL = 16,
    parameter int GUARD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    home_event_arbiter_if.slave  bus
);

    localparam logic [7:0] DWELL_LD = 8'(DWELL - 1);
    localparam logic [7:0] GUARD_LD = (GUARD == 0) ? 8'd0 : 8'(GUARD - 1);
    localparam bit         NO_GUARD = (GUARD == 0);

    state_t            state;
    logic [7:0]        cnt;
    logic [2:0]        sel_q;
    logic [2:0]        rr_ptr;
    logic [NUM_CH-1:0] prev_req;
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] grant_q;
    logic [2:0]        disp_q;
    logic              busy_q;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] rise;
    logic [2:0]        pick_sel;
    logic              pick_vld;
    logic              preempt;
    logic              dwell_done;
    logic              do_grant;
    logic [2:0]        grant_ch;
    logic [NUM_CH-1:0] repend;
    logic [NUM_CH-1:0] set_mask;
    logic [NUM_CH-1:0] clr;

    // Heat and cool requests are exclusive because they decode disjoint temp ranges.
    assign req  = {bus.temp[5], (bus.temp[5:4] == 2'b00), bus.sensors};
    assign rise = req & ~prev_req;

    rr_pick6 u_pick (
        .pending (pending_q),
        .rr_ptr  (rr_ptr),
        .sel     (pick_sel),
        .valid   (pick_vld)
    );

    always_comb begin
        preempt    = rise[CH_FA] &&
                     (((state == ST_GRANT) && (sel_q != CH_FA)) || (state == ST_GUARD));
        dwell_done = (state == ST_GRANT) && (cnt == 8'd0);
        do_grant   = preempt || (pick_vld && ((state == ST_IDLE) || (dwell_done && NO_GUARD)));
        grant_ch   = preempt ? CH_FA : pick_sel;
        // An interrupted grant goes back into the pending set to be served in full later.
        repend     = (preempt && (state == ST_GRANT) && (cnt != 8'd0)) ? ch_onehot(sel_q) : '0;
        // A preempting fire rise is consumed by the grant itself, not left pending.
        set_mask   = preempt ? (rise & ~ch_onehot(CH_FA)) : rise;
        clr        = do_grant ? ch_onehot(grant_ch) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 8'd0;
            sel_q     <= CH_FD;
            rr_ptr    <= CH_COOL;
            prev_req  <= '0;
            pending_q <= '0;
            grant_q   <= '0;
            disp_q    <= DISP_IDLE;
            busy_q    <= 1'b0;
        end else begin
            prev_req  <= req;
            pending_q <= (pending_q & ~clr) | repend | set_mask;
            if (do_grant) begin
                state   <= ST_GRANT;
                cnt     <= DWELL_LD;
                sel_q   <= grant_ch;
                grant_q <= ch_onehot(grant_ch);
                disp_q  <= ch_disp(grant_ch);
                busy_q  <= 1'b1;
                if (grant_ch != CH_FA) begin
                    rr_ptr <= grant_ch;
                end
            end else begin
                case (state)
                    ST_GRANT: begin
                        if (cnt == 8'd0) begin
                            grant_q <= '0;
                            disp_q  <= DISP_IDLE;
                            if (NO_GUARD) begin
                                state  <= ST_IDLE;
                                busy_q <= 1'b0;
                            end else begin
                                state  <= ST_GUARD;
                                cnt    <= GUARD_LD;
                                busy_q <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    ST_GUARD: begin
                        if (cnt == 8'd0) begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.grant   = grant_q;
    assign bus.display = disp_q;
    assign bus.pending = pending_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_home_event_arbiter.sv
// Directed bench for home_event_arbiter: default timing on one instance, GUARD=0/DWELL=1 on another.
module tb_home_event_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    home_event_arbiter_if bus_a ();
    home_event_arbiter_if bus_b ();

    home_event_arbiter #(.DWELL(16), .GUARD(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    home_event_arbiter #(.DWELL(1), .GUARD(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int total = 0;
    int bad   = 0;

    int         gap;
    int         gb;
    int         len;
    int         n;
    logic [5:0] g;

    logic [5:0] t2_g [3] = '{6'b000001, 6'b000010, 6'b001000};
    logic [5:0] t2_p [3] = '{6'b001010, 6'b001000, 6'b000000};
    logic [5:0] t6_g [4] = '{6'b000001, 6'b000010, 6'b001000, 6'b000000};
    logic [2:0] t6_d [4] = '{3'd1, 3'd2, 3'd4, 3'd0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int gp, output int gpb);
        gp  = 0;
        gpb = 0;
        while (bus_a.grant == 6'd0 && gp < 200) begin
            if (bus_a.busy) gpb++;
            gp++;
            tick();
        end
        if (gp >= 200) check("grant_timeout", gp, 0);
    endtask

    task automatic hold_len(output logic [5:0] gg, output int ln);
        gg = bus_a.grant;
        ln = 0;
        while (bus_a.grant == gg && ln < 300) begin
            ln++;
            tick();
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus_a.busy && k < 100) begin
            k++;
            tick();
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus_a.sensors = 4'b0000;
        bus_a.temp    = 6'd20;
        bus_b.sensors = 4'b0000;
        bus_b.temp    = 6'd20;
        repeat (2) tick();

        check("rst_grant",   bus_a.grant,   0);
        check("rst_display", bus_a.display, 0);
        check("rst_pending", bus_a.pending, 0);
        check("rst_busy",    bus_a.busy,    0);

        // 1: single front-door event, full dwell and guard
        rst           = 1'b0;
        bus_a.sensors = 4'b0001;
        tick();
        check("t1_pending", bus_a.pending, 6'b000001);
        check("t1_nogrant", bus_a.grant,   0);
        wait_grant(gap, gb);
        check("t1_latency", gap, 1);
        check("t1_grant",   bus_a.grant,   6'b000001);
        check("t1_display", bus_a.display, 1);
        check("t1_pclr",    bus_a.pending, 0);
        hold_len(g, len);
        check("t1_dwell", len, 16);
        n = 0;
        while (bus_a.busy && bus_a.grant == 6'd0 && n < 50) begin
            n++;
            tick();
        end
        check("t1_guard",     n, 4);
        check("t1_idle_busy", bus_a.busy,    0);
        check("t1_idle_disp", bus_a.display, 0);

        // 2: FD, RD, W together after a fresh reset
        bus_a.sensors = 4'b0000;
        rst = 1'b1;
        repeat (2) tick();
        rst           = 1'b0;
        bus_a.sensors = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            wait_grant(gap, gb);
            if (k > 0) check("t2_guard", gb, 4);
            check("t2_grant",   bus_a.grant,   t2_g[k]);
            check("t2_pending", bus_a.pending, t2_p[k]);
            hold_len(g, len);
            check("t2_dwell", len, 16);
        end

        // 3: heater requested mid-FD, cooler requested mid-heater
        bus_a.sensors = 4'b0000;
        wait_idle();
        bus_a.sensors = 4'b0001;
        wait_grant(gap, gb);
        check("t3_fd", bus_a.grant, 6'b000001);
        tick();
        tick();
        bus_a.temp = 6'd10;
        hold_len(g, len);
        check("t3_fd_rest",  len, 14);
        check("t3_pend_heat", bus_a.pending, 6'b010000);
        wait_grant(gap, gb);
        check("t3_heat_guard", gb, 4);
        check("t3_heat",      bus_a.grant,   6'b010000);
        check("t3_heat_disp", bus_a.display, 5);
        bus_a.temp = 6'd40;
        hold_len(g, len);
        check("t3_heat_dwell", len, 16);
        check("t3_pend_cool",  bus_a.pending, 6'b100000);
        wait_grant(gap, gb);
        check("t3_cool_guard", gb, 4);
        check("t3_cool",      bus_a.grant,   6'b100000);
        check("t3_cool_disp", bus_a.display, 6);
        hold_len(g, len);
        check("t3_cool_dwell", len, 16);

        // 4: fire preempts an RD grant, RD then re-served in full
        bus_a.temp = 6'd20;
        wait_idle();
        bus_a.sensors = 4'b0010;
        wait_grant(gap, gb);
        check("t4_rd", bus_a.grant, 6'b000010);
        repeat (4) tick();
        bus_a.sensors = 4'b0110;
        tick();
        check("t4_fire",      bus_a.grant,   6'b000100);
        check("t4_fire_disp", bus_a.display, 3);
        check("t4_rd_repend", bus_a.pending, 6'b000010);
        hold_len(g, len);
        check("t4_fire_dwell", len, 16);
        wait_grant(gap, gb);
        check("t4_rd_guard", gb, 4);
        check("t4_rd_again", bus_a.grant,   6'b000010);
        check("t4_rd_pclr",  bus_a.pending, 0);
        hold_len(g, len);
        check("t4_rd_dwell", len, 16);

        // 5: reset mid-grant with events pending, then relatch from held levels
        bus_a.sensors = 4'b0000;
        wait_idle();
        bus_a.sensors = 4'b0010;
        wait_grant(gap, gb);
        check("t5_rd", bus_a.grant, 6'b000010);
        bus_a.sensors = 4'b1011;
        bus_a.temp    = 6'd40;
        tick();
        check("t5_pending", bus_a.pending, 6'b101001);
        check("t5_still_rd", bus_a.grant,  6'b000010);
        rst = 1'b1;
        tick();
        check("t5_rst_grant", bus_a.grant,   0);
        check("t5_rst_disp",  bus_a.display, 0);
        check("t5_rst_pend",  bus_a.pending, 0);
        check("t5_rst_busy",  bus_a.busy,    0);
        rst = 1'b0;
        tick();
        check("t5_relatch", bus_a.pending, 6'b101011);
        check("t5_nogrant", bus_a.grant,   0);
        tick();
        check("t5_first_fd", bus_a.grant, 6'b000001);

        // 6: GUARD=0, DWELL=1 back-to-back grants
        bus_b.sensors = 4'b1011;
        tick();
        check("t6_pending", bus_b.pending, 6'b001011);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("t6_grant",  bus_b.grant,   t6_g[k]);
            check("t6_disp",   bus_b.display, t6_d[k]);
            check("t6_busy",   bus_b.busy,    (k < 3) ? 1 : 0);
            check("t6_onehot", $countones(bus_b.grant), (k < 3) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
